// File: rtl/instruction_sequencer_pkg.sv
// Shared CPU definitions: opcode constants and sequencer state encoding.
package instruction_sequencer_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 2;

   localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
   localparam logic [OP_W-1:0] OP_JUMP = 6'b000010;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OP_W-1:0] OP_IN   = 6'b011011;
   localparam logic [OP_W-1:0] OP_OUT  = 6'b011100;
   localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN     = 2'd0,
      ST_IO_WAIT = 2'd1,
      ST_HALTED  = 2'd2
   } seq_state_e;

   // Any makeIO opcode other than In is handled as an Out transfer.
   function automatic logic is_input_op(input logic [OP_W-1:0] op);
      return (op == OP_IN);
   endfunction

endpackage

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: owns the PC, presents the opcode to the control unit,
// and steps the core through RUN / IO_WAIT / HALTED using the decoded strobes.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   instruction         word at pc (combinational imem read)
//   halt/jump/branch/makeIO   control-unit decodes
//   branchTaken         ALU compare result
//   ioAck               IO device completion
//   resume              leave HALTED
//   opcode              instruction[31:26] (combinational)
//   pc                  current instruction address
//   commit              instruction completes this cycle (combinational)
//   ioRequest           IO transfer pending
//   ioIsInput           1 = In, 0 = Out
//   halted              core is halted
//   retired             committed-instruction count
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              halt,
   input  logic              jump,
   input  logic              branch,
   input  logic              makeIO,
   input  logic              branchTaken,
   input  logic              ioAck,
   input  logic              resume,
   output logic [OP_W-1:0]   opcode,
   output logic [ADDR_W-1:0] pc,
   output logic              commit,
   output logic              ioRequest,
   output logic              ioIsInput,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              is_input_q, is_input_d;
   logic              commit_c;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] target;

   // Only the low ADDR_W bits of the word form the target; the rest is decoded elsewhere.
   logic              unused_instr;
   assign unused_instr = ^instruction;

   assign opcode = instruction[31:26];
   assign pc_inc = pc_q + ADDR_W'(1);
   assign target = instruction[ADDR_W-1:0];

   // State, PC, counter and IO-direction registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_RUN;
         pc_q       <= ADDR_W'(RESET_PC);
         retired_q  <= '0;
         is_input_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         retired_q  <= retired_d;
         is_input_q <= is_input_d;
      end
   end

   // Next-state, next-PC and commit decode.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      retired_d  = retired_q;
      is_input_d = is_input_q;
      commit_c   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            commit_c = !makeIO || halt;
            if (halt) begin
               state_d   = ST_HALTED;
               retired_d = retired_q + CNT_W'(1);
            end else if (makeIO) begin
               state_d    = ST_IO_WAIT;
               is_input_d = is_input_op(opcode);
            end else if (jump || (branch && branchTaken)) begin
               pc_d      = target;
               retired_d = retired_q + CNT_W'(1);
            end else begin
               pc_d      = pc_inc;
               retired_d = retired_q + CNT_W'(1);
            end
         end
         ST_IO_WAIT: begin
            if (ioAck) begin
               commit_c  = 1'b1;
               pc_d      = pc_inc;
               retired_d = retired_q + CNT_W'(1);
               state_d   = ST_RUN;
            end
         end
         ST_HALTED: begin
            if (resume) begin
               pc_d    = pc_inc;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Commit is suppressed while reset is held so no write escapes during reset.
   assign commit    = reset && commit_c;
   assign pc        = pc_q;
   assign retired   = retired_q;
   assign ioIsInput = is_input_q;
   assign ioRequest = (state_q == ST_IO_WAIT);
   assign halted    = (state_q == ST_HALTED);

endmodule
